tx_burst_sequencer: RTL and testbench

//  Sits directly downstream of the EN-button debouncer. Fires one ultrasound transmit burst
//  per debounced rising edge of the trigger: N bipolar pulses on tx_p/tx_n, then a delayed

---
 rtl/tx_burst_sequencer_if.sv | 27 ++
 rtl/tx_burst_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_tx_burst_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/tx_burst_sequencer_if.sv
// Trigger/config and pulser/receive-gate signals of tx_burst_sequencer.
// The master side drives the trigger and burst configuration; the slave side is the sequencer.
interface tx_burst_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             trig_in;
    logic [7:0]       n_pulses;
    logic [CNT_W-1:0] half_period;
    logic [CNT_W-1:0] rx_delay;
    logic [CNT_W-1:0] rx_window;
    logic             tx_p;
    logic             tx_n;
    logic             rx_gate;
    logic             busy;
    logic             done;
    logic [15:0]      burst_cnt;

    modport master (
        output trig_in, n_pulses, half_period, rx_delay, rx_window,
        input  tx_p, tx_n, rx_gate, busy, done, burst_cnt
    );

    modport slave (
        input  trig_in, n_pulses, half_period, rx_delay, rx_window,
        output tx_p, tx_n, rx_gate, busy, done, burst_cnt
    );
endinterface

// File: rtl/tx_burst_sequencer.sv
// One bipolar ultrasound burst plus delayed receive gate per debounced trigger press.
// Define TX_DEADTIME_EN to insert DEADTIME idle cycles between polarity phases.
module tx_burst_sequencer #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DEADTIME = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tx_burst_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE,
        TX_P,
        TX_N,
        DEAD,
        RX_WAIT,
        RX_GATE,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic             trig_q;
    logic             start;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       pulse_q, pulse_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic             dead_to_n_q, dead_to_n_d;
    logic             go_rx;
    logic             go_gate;
    logic             done_d;

    logic             tx_p_q;
    logic             tx_n_q;
    logic             rx_gate_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      burst_q;

    // trig_q resets high so a trigger held through reset release never fires
    assign start = bus.trig_in & ~trig_q & (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_d     = pulse_q;
        hp_d        = hp_q;
        dly_d       = dly_q;
        win_d       = win_q;
        dead_to_n_d = dead_to_n_q;
        go_rx       = 1'b0;
        go_gate     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    hp_d    = (bus.half_period == CNT_ZERO) ? CNT_ONE : bus.half_period;
                    dly_d   = bus.rx_delay;
                    win_d   = bus.rx_window;
                    pulse_d = bus.n_pulses;
                    if (bus.n_pulses == 8'd0) begin
                        go_rx = 1'b1;
                    end else begin
                        state_d = TX_P;
                        cnt_d   = hp_d - CNT_ONE;
                    end
                end
            end
            TX_P: begin
                if (cnt_q == CNT_ZERO) begin
`ifdef TX_DEADTIME_EN
                    state_d     = DEAD;
                    cnt_d       = CNT_W'(DEADTIME - 1);
                    dead_to_n_d = 1'b1;
`else
                    state_d     = TX_N;
                    cnt_d       = hp_q - CNT_ONE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            TX_N: begin
                if (cnt_q == CNT_ZERO) begin
                    pulse_d = pulse_q - 8'd1;
                    if (pulse_q == 8'd1) begin
                        go_rx = 1'b1;
                    end else begin
`ifdef TX_DEADTIME_EN
                        state_d     = DEAD;
                        cnt_d       = CNT_W'(DEADTIME - 1);
                        dead_to_n_d = 1'b0;
`else
                        state_d     = TX_P;
                        cnt_d       = hp_q - CNT_ONE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DEAD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = dead_to_n_q ? TX_N : TX_P;
                    cnt_d   = hp_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RX_WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    go_gate = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RX_GATE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (!bus.trig_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Zero-length delay or window collapses straight into the following phase
        if (go_rx) begin
            if (dly_d != CNT_ZERO) begin
                state_d = RX_WAIT;
                cnt_d   = dly_d - CNT_ONE;
            end else begin
                go_gate = 1'b1;
            end
        end
        if (go_gate) begin
            if (win_d != CNT_ZERO) begin
                state_d = RX_GATE;
                cnt_d   = win_d - CNT_ONE;
            end else begin
                state_d = HOLD;
            end
        end
    end

    assign done_d = (state_d == HOLD) && (state_q != HOLD);

    // Outputs are registered from the next state so they align with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q      <= 1'b1;
            cnt_q       <= '0;
            pulse_q     <= '0;
            hp_q        <= '0;
            dly_q       <= '0;
            win_q       <= '0;
            dead_to_n_q <= 1'b0;
            tx_p_q      <= 1'b0;
            tx_n_q      <= 1'b0;
            rx_gate_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            burst_q     <= '0;
        end else begin
            trig_q      <= bus.trig_in;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            hp_q        <= hp_d;
            dly_q       <= dly_d;
            win_q       <= win_d;
            dead_to_n_q <= dead_to_n_d;
            tx_p_q      <= (state_d == TX_P);
            tx_n_q      <= (state_d == TX_N);
            rx_gate_q   <= (state_d == RX_GATE);
            busy_q      <= (state_d != IDLE);
            done_q      <= done_d;
            if (done_d) begin
                burst_q <= burst_q + 16'd1;
            end
        end
    end

    assign bus.tx_p      = tx_p_q;
    assign bus.tx_n      = tx_n_q;
    assign bus.rx_gate   = rx_gate_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.burst_cnt = burst_q;

endmodule

// File: tb/tb_tx_burst_sequencer.sv
// Directed bench for tx_burst_sequencer: per-cycle output vectors against a phase-schedule model.
`timescale 1ns/1ps
module tb_tx_burst_sequencer;

    localparam int unsigned CNT_W = 16;
`ifdef TX_DEADTIME_EN
    localparam int DT = 2;
`else
    localparam int DT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tx_burst_sequencer_if #(.CNT_W(CNT_W)) bus ();

    tx_burst_sequencer #(
        .CNT_W    (CNT_W),
        .DEADTIME (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {tx_p, tx_n, rx_gate, done, busy} expected i cycles after the start edge (trigger held high)
    function automatic logic [4:0] exp_vec(int i, int n, int hp, int dly, int win);
        int   hpe;
        int   seg_len;
        int   tx_len;
        int   j;
        logic tp;
        logic tn;
        logic g;
        logic d;
        hpe     = (hp == 0) ? 1 : hp;
        seg_len = hpe + DT;
        tx_len  = (n == 0) ? 0 : n * 2 * hpe + (2 * n - 1) * DT;
        tp = 1'b0; tn = 1'b0; g = 1'b0; d = 1'b0;
        if (i >= 1 && i <= tx_len) begin
            j = i - 1;
            if ((j % seg_len) < hpe) begin
                if (((j / seg_len) % 2) == 0) tp = 1'b1;
                else                          tn = 1'b1;
            end
        end
        if (i > tx_len + dly && i <= tx_len + dly + win) g = 1'b1;
        if (i == tx_len + dly + win + 1) d = 1'b1;
        return {tp, tn, g, d, 1'b1};
    endfunction

    function automatic logic [4:0] outs();
        return {bus.tx_p, bus.tx_n, bus.rx_gate, bus.done, bus.busy};
    endfunction

    task automatic run_burst(input string name, input int n, input int hp, input int dly,
                             input int win, input bit toggle, input logic [15:0] exp_cnt);
        int hpe;
        int total;
        hpe   = (hp == 0) ? 1 : hp;
        total = ((n == 0) ? 0 : n * 2 * hpe + (2 * n - 1) * DT) + dly + win + 2;
        @(negedge clk);
        bus.n_pulses    = 8'(n);
        bus.half_period = CNT_W'(hp);
        bus.rx_delay    = CNT_W'(dly);
        bus.rx_window   = CNT_W'(win);
        bus.trig_in     = 1'b1;
        for (int i = 1; i <= total; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s_c%0d", name, i), 32'(outs()), 32'(exp_vec(i, n, hp, dly, win)));
            // config changes mid-burst must be ignored
            bus.n_pulses    = 8'd7;
            bus.half_period = CNT_W'(9);
            if (toggle && i == 3) bus.trig_in = 1'b0;
            if (toggle && i == 4) bus.trig_in = 1'b1;
        end
        check({name, "_cnt"}, 32'(bus.burst_cnt), 32'(exp_cnt));
    endtask

    task automatic release_trig(input string name);
        bus.trig_in = 1'b0;
        @(negedge clk);
        check({name, "_busy_low"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic act;
        int   mid;

        // 1: trigger held high through reset release never fires
        bus.trig_in     = 1'b1;
        bus.n_pulses    = 8'd3;
        bus.half_period = CNT_W'(4);
        bus.rx_delay    = CNT_W'(5);
        bus.rx_window   = CNT_W'(8);
        repeat (3) @(negedge clk);
        check("rst_outs", 32'(outs()), 32'd0);
        check("rst_cnt", 32'(bus.burst_cnt), 32'd0);
        rst_n = 1'b1;
        act = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            act = act | (|outs());
        end
        check("held_trig_activity", 32'(act), 32'd0);
        check("held_trig_cnt", 32'(bus.burst_cnt), 32'd0);
        bus.trig_in = 1'b0;
        repeat (2) @(negedge clk);

        // 2: three pulses, delayed gate
        run_burst("t2", 3, 4, 5, 8, 1'b0, 16'd1);
        release_trig("t2");

        // 3: no TX, zero delay, two-cycle gate
        run_burst("t3", 0, 0, 0, 2, 1'b0, 16'd2);
        release_trig("t3");

        // 4: trigger toggled mid-burst, then held high after done
        run_burst("t4", 1, 2, 1, 1, 1'b1, 16'd3);
        act = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            act = act | bus.tx_p | bus.tx_n | bus.rx_gate | bus.done | ~bus.busy;
        end
        check("t4_hold_busy", 32'(act), 32'd0);
        check("t4_one_burst", 32'(bus.burst_cnt), 32'd3);
        release_trig("t4");

`ifdef TX_DEADTIME_EN
        // 6: deadtime schedule and burst counter wrap
        @(negedge clk);
        force dut.burst_q = 16'hFFFF;
        @(negedge clk);
        release dut.burst_q;
        run_burst("t6", 2, 3, 1, 1, 1'b0, 16'h0000);
        release_trig("t6");
`endif

        // 5: reset asserted during the second pulse's positive phase
        @(negedge clk);
        bus.n_pulses    = 8'd3;
        bus.half_period = CNT_W'(4);
        bus.rx_delay    = CNT_W'(5);
        bus.rx_window   = CNT_W'(8);
        bus.trig_in     = 1'b1;
        mid = 2 * (4 + DT) + 2;
        for (int i = 1; i <= mid; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("t5_pre_rst_txp", 32'(bus.tx_p), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_outs", 32'(outs()), 32'd0);
        check("t5_async_cnt", 32'(bus.burst_cnt), 32'd0);
        bus.trig_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        act = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            act = act | (|outs());
        end
        check("t5_no_done", 32'(act), 32'd0);
        check("t5_cnt", 32'(bus.burst_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
